// File: rtl/cc_tag_wctl_pkg.sv
// Shared types and sizes for the tag-array write controller and its eviction FIFO.
package cc_tag_wctl_pkg;

    localparam int unsigned LINE_W         = 37;
    localparam int unsigned NUM_WAYS       = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned HIT_CNT_W      = $clog2(NUM_WAYS + 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } wctl_state_e;

    typedef enum logic {
        OP_INV  = 1'b0,
        OP_FILL = 1'b1
    } wctl_op_e;

endpackage

// File: rtl/cc_exp_fifo.sv
// Eviction-address FIFO; pops only when non-empty, pushes only when a slot is free or being freed.
module cc_exp_fifo
    import cc_tag_wctl_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned WIDTH = LINE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             pop_ok;
    logic             push_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rptr];

    always_ff @(negedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(negedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cc_tag_wctl.sv
// Tag-array write controller: init walk, invalidate and fill sequencing, victim capture into the eviction FIFO.
module cc_tag_wctl
    import cc_tag_wctl_pkg::*;
#(
    parameter int unsigned IDX_BITS   = 7,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init_req,
    input  logic                         inv_valid,
    output logic                         inv_ready,
    input  logic [LINE_W-1:0]            inv_paddr,
    input  logic                         fill_valid,
    output logic                         fill_ready,
    input  logic [LINE_W-1:0]            fill_paddr,
    output logic [LINE_W-1:0]            tag_write_phys_addr,
    output logic                         tag_write_wen,
    output logic                         tag_invalidate,
    output logic                         tag_init,
    input  logic [NUM_WAYS-1:0]          tag_write_hit,
    input  logic [NUM_WAYS-1:0]          tag_exp_en,
    input  logic [NUM_WAYS*LINE_W-1:0]   tag_expun_addr,
    output logic                         exp_valid,
    input  logic                         exp_ready,
    output logic [LINE_W-1:0]            exp_paddr,
    output logic                         inv_hit,
    output logic                         way_err,
    output logic                         busy
);

    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

    wctl_state_e            state;
    wctl_state_e            state_nxt;
    wctl_op_e               op;
    logic [IDX_BITS-1:0]    idx;
    logic [HIT_CNT_W-1:0]   hit_cnt;
    logic [LINE_W-1:0]      sel_addr;
    logic                   sel_en;
    logic                   resp_commit;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic [FIFO_CNT_W-1:0]  fifo_count;

    always_ff @(negedge clk) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Everything is held quiet while reset is low so no strobe reaches the arrays.
    always_comb begin
        state_nxt           = state;
        inv_ready           = 1'b0;
        fill_ready          = 1'b0;
        tag_init            = 1'b0;
        tag_invalidate      = 1'b0;
        tag_write_wen       = 1'b0;
        tag_write_phys_addr = '0;
        if (rst) begin
            case (state)
                ST_INIT: begin
                    tag_init            = 1'b1;
                    tag_write_phys_addr = LINE_W'(idx);
                    if (idx == IDX_LAST) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (init_req) begin
                        state_nxt = ST_INIT;
                    end else begin
                        inv_ready  = 1'b1;
                        fill_ready = !inv_valid && !fifo_full;
                        if (inv_valid) begin
                            tag_invalidate      = 1'b1;
                            tag_write_phys_addr = inv_paddr;
                            state_nxt           = ST_RESP;
                        end else if (fill_valid && !fifo_full) begin
                            tag_write_wen       = 1'b1;
                            tag_write_phys_addr = fill_paddr;
                            state_nxt           = ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    state_nxt = init_req ? ST_INIT : ST_IDLE;
                end
                default: begin
                    state_nxt = ST_INIT;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // Walk index restarts from zero on every entry into INIT.
    always_ff @(negedge clk) begin
        if (!rst) begin
            idx <= '0;
            op  <= OP_INV;
        end else begin
            idx <= (state == ST_INIT) ? idx + IDX_BITS'(1) : '0;
            if (tag_invalidate || tag_write_wen) begin
                op <= tag_write_wen ? OP_FILL : OP_INV;
            end
        end
    end

    // Popcount and hit-way victim select.
    always_comb begin
        hit_cnt  = '0;
        sel_addr = '0;
        sel_en   = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            hit_cnt = hit_cnt + HIT_CNT_W'(tag_write_hit[w]);
            if (tag_write_hit[w]) begin
                sel_addr = tag_expun_addr[w*LINE_W +: LINE_W];
                sel_en   = tag_exp_en[w];
            end
        end
    end

    assign resp_commit = rst && (state == ST_RESP) && !init_req;
    assign fifo_push   = resp_commit && (op == OP_FILL) && (hit_cnt == HIT_CNT_W'(1)) && sel_en;
    assign fifo_pop    = exp_valid && exp_ready;
    assign exp_valid   = (fifo_count != '0);

    always_ff @(negedge clk) begin
        if (!rst) begin
            inv_hit <= 1'b0;
            way_err <= 1'b0;
        end else begin
            inv_hit <= resp_commit && (op == OP_INV) && (|tag_write_hit);
            way_err <= resp_commit && (op == OP_FILL) && (hit_cnt != HIT_CNT_W'(1));
        end
    end

    cc_exp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LINE_W)
    ) u_exp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (sel_addr),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .count     (fifo_count),
        .head      (exp_paddr)
    );

endmodule

// File: doc/cc_tag_wctl.md
CC_TAG_WCTL -- requirements
Module: cc_tag_wctl

Interface
REQ-001 SHALL have parameter IDX_BITS, default 7, set-index width (128 sets; 8 when ICACHE_256K).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, eviction FIFO entries (power of two).
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  single clock; all state updates on negedge clk, matching the tag arrays
  rst  in  1  reset, synchronous, active-low (asserted when 0)
  init_req  in  1  pulse: start a full tag-array clear
  inv_valid / inv_ready  in/out  1/1  invalidate request handshake
  inv_paddr  in  37  physical line address to invalidate
  fill_valid / fill_ready  in/out  1/1  fill request handshake
  fill_paddr  in  37  physical line address to allocate
  tag_write_phys_addr  out  37  write address to all 8 ways
  tag_write_wen  out  1  fill strobe to all ways
  tag_invalidate  out  1  invalidate strobe to all ways
  tag_init  out  1  init strobe to all ways
  tag_write_hit  in  8  per-way write_hit, valid one cycle after strobe
  tag_exp_en  in  8  per-way expunge-valid, same cycle as tag_write_hit
  tag_expun_addr  in  296  8 x 37 per-way victim address, way w at [37w+36:37w]
  exp_valid / exp_ready  out/in  1/1  evicted-line output handshake
  exp_paddr  out  37  evicted line address
  inv_hit  out  1  pulse: invalidate matched at least one way
  way_err  out  1  pulse: fill selected zero or more than one way
  busy  out  1  init walk or op in flight

Function
REQ-004 SHALL implement FSM states INIT, IDLE, RESP.
REQ-005 INIT: tag_init=1, tag_write_phys_addr={zeros, idx}; idx runs 0..2^IDX_BITS-1, one per cycle; after last index -> IDLE; walk SHALL take exactly 2^IDX_BITS cycles.
REQ-006 IDLE priority: init_req > inv_valid > fill_valid; init_req in IDLE or RESP -> INIT with idx=0 (RESP result discarded, no push, no pulses).
REQ-007 inv_ready=1 only in IDLE with init_req=0; on handshake drive tag_invalidate=1, tag_write_phys_addr=inv_paddr for one cycle -> RESP.
REQ-008 fill_ready=1 only in IDLE, init_req=0, inv_valid=0, and FIFO count < FIFO_DEPTH; on handshake drive tag_write_wen=1, tag_write_phys_addr=fill_paddr for one cycle -> RESP.
REQ-009 Strobes SHALL be 0 in every cycle not named above; at most one strobe high per cycle.
REQ-010 RESP lasts exactly one cycle, samples tag_write_hit/tag_exp_en/tag_expun_addr, then -> IDLE; throughput one op per 2 cycles.
REQ-011 RESP after invalidate: inv_hit=|tag_write_hit for one cycle; no FIFO push.
REQ-012 RESP after fill: popcount(tag_write_hit)!=1 -> way_err=1 one cycle, no push; exactly one hit way w with tag_exp_en[w]=1 -> push tag_expun_addr[w]; tag_exp_en[w]=0 -> no push.
REQ-013 FIFO: exp_valid=count!=0, exp_paddr=head; pop on exp_valid&&exp_ready; simultaneous push/pop when full or empty SHALL be legal, count unchanged when both, pointers wrap modulo FIFO_DEPTH.
REQ-014 Push never overflows: REQ-008 gating guarantees a free slot at RESP.
REQ-015 busy=1 in INIT and RESP, 0 in IDLE.
REQ-016 init_req SHALL NOT flush the FIFO.

Reset
REQ-017 rst=0 at a clock edge: state=INIT, idx=0, FIFO empty, inv_hit=way_err=0, all strobes 0 in that cycle; after rst=1 the INIT walk starts automatically.
REQ-018 rst=0 mid-walk or mid-RESP SHALL abandon the operation with no push and no pulse.

Structure
REQ-019 Shared package SHALL hold: line-address width 37, way count 8, FIFO_DEPTH default, FSM state enum.
REQ-020 FIFO SHALL be sub-module cc_exp_fifo (push, pop, full, count, head); way-select mux and popcount stay in cc_tag_wctl.

Verification
REQ-021 Reset release, IDX_BITS=7 -> tag_init high 128 cycles, addresses 0..127 in order, then fill_ready=1.
REQ-022 Fill 0x1234, response hit=8'h04, exp_en=8'h04, way2 addr=0xABC -> exp_valid next cycle, exp_paddr=0xABC, way_err=0.
REQ-023 Fill response hit=8'h00, then hit=8'h11 -> way_err pulses twice, FIFO count 0.
REQ-024 Invalidate and fill valid same cycle -> invalidate issued first, fill two cycles later; hit=8'h80 -> inv_hit=1.
REQ-025 exp_ready=0, 4 evicting fills -> count=4, fill_ready=0; exp_ready=1 with fill pending -> pop and later push coexist, order preserved.
REQ-026 init_req during RESP of an evicting fill -> no push, walk restarts at idx 0, FIFO contents retained.
